// File: rtl/ofm_pkg.sv
// Shared definitions for the OFM FIFO reader.
//   - ofm_state_e : reader FSM states
//   - DefDataWidth / DefFifoSize : default FIFO word width and depth
//   - occ_width() : width of the occupancy counter (must hold 0..fifo_size inclusive)
package ofm_pkg;

  localparam int unsigned DefDataWidth = 256;
  localparam int unsigned DefFifoSize  = 512;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StFlush,
    StDone
  } ofm_state_e;

  // One extra bit so a completely full FIFO is representable.
  function automatic int unsigned occ_width(input int unsigned fifo_size);
    return $clog2(fifo_size) + 1;
  endfunction

endpackage

// File: rtl/ofm_skid_buf.sv
// Two-entry output buffer between the FIFO read port and the output stream.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready/in_data/in_last   write side (one word per cycle)
//   out_valid/out_ready/out_data/out_last  stream side; head entry held while stalled
//   count                               current number of held entries (0..2)
module ofm_skid_buf
  import ofm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            count
);

  // Each entry stores {last, data}.
  logic [DATA_WIDTH:0] ent_q [2];
  logic [DATA_WIDTH:0] ent_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                push, pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = ent_q[rd_ptr_q][DATA_WIDTH-1:0];
  // Gated so the flag never shows on a stale entry (e.g. right after reset).
  assign out_last  = out_valid & ent_q[rd_ptr_q][DATA_WIDTH];
  assign count     = cnt_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      ent_d[wr_ptr_q] = {in_last, in_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset: validity is carried by cnt_q.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: rtl/ofm_fifo_reader.sv
// Drains a requested number of words from the attached OFM FIFO onto a valid/ready stream.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   start, num_words              drain request (accepted only when idle)
//   fifo_wr_en_mon                copy of the FIFO write strobe, used to track occupancy
//   fifo_rd_en, fifo_rd_data      FIFO read strobe; data arrives the following cycle
//   fifo_rd_clr_n, fifo_wr_clr_n  active-low FIFO pointer clears
//   m_valid/m_ready/m_data/m_last output stream
//   busy, done, ovf_err           not idle; completion pulse; sticky overflow
module ofm_fifo_reader
  import ofm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned FIFO_SIZE  = DefFifoSize,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_words,
  input  logic                  fifo_wr_en_mon,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  fifo_rd_clr_n,
  output logic                  fifo_wr_clr_n,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf_err
);

  localparam int unsigned    OccW   = occ_width(FIFO_SIZE);
  localparam logic [OccW-1:0] OccMax = OccW'(FIFO_SIZE);

  ofm_state_e       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             inflight_q, inflight_d;
  logic             last_inflight_q, last_inflight_d;

  logic [1:0]       buf_cnt;
  logic             buf_in_ready;
  logic             pop;
  logic             space_ok;
  logic             rd_en;
  logic             flush_done;

  assign pop = m_valid & m_ready;

  // Words already committed (buffered + in flight) minus the one leaving this cycle must leave
  // room for one more, so the buffer can never be overrun.
  assign space_ok = ({1'b0, buf_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  assign rd_en = (state_q == StRun) && (occ_q != '0) && (remaining_q != '0) && space_ok;

  // Look ahead by the current pop so done follows the final word by exactly one cycle.
  assign flush_done = !inflight_q && ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && pop));

  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    occ_d           = occ_q;
    ovf_d           = ovf_q;
    inflight_d      = rd_en;
    last_inflight_d = rd_en && (remaining_q == CNT_W'(1));

    // Occupancy mirrors the FIFO; writes seen while the FIFO is being cleared are discarded.
    if (state_q == StClear) begin
      occ_d = '0;
    end else if (fifo_wr_en_mon && !rd_en) begin
      if (occ_q == OccMax) begin
        ovf_d = 1'b1;
      end else begin
        occ_d = occ_q + OccW'(1);
      end
    end else if (!fifo_wr_en_mon && rd_en) begin
      occ_d = occ_q - OccW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d = num_words;
          ovf_d       = 1'b0;
          state_d     = StClear;
        end
      end
      StClear: begin
        state_d = (remaining_q == '0) ? StDone : StRun;
      end
      StRun: begin
        if (rd_en) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (flush_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      remaining_q     <= '0;
      occ_q           <= '0;
      ovf_q           <= 1'b0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      occ_q           <= occ_d;
      ovf_q           <= ovf_d;
      inflight_q      <= inflight_d;
      last_inflight_q <= last_inflight_d;
    end
  end

  ofm_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (inflight_q),
    .in_ready (buf_in_ready),
    .in_data  (fifo_rd_data),
    .in_last  (last_inflight_q),
    .out_valid(m_valid),
    .out_ready(m_ready),
    .out_data (m_data),
    .out_last (m_last),
    .count    (buf_cnt)
  );

  // The read gating guarantees a free slot for every word in flight.
  buf_space_a : assert property (@(posedge clk) disable iff (!rst_n) inflight_q |-> buf_in_ready);

  // Clears are held during reset as well, so the FIFO comes up empty alongside the reader.
  assign fifo_rd_clr_n = rst_n & (state_q != StClear);
  assign fifo_wr_clr_n = rst_n & (state_q != StClear);
  assign fifo_rd_en    = rd_en;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_ofm_fifo_reader.sv
module tb_ofm_fifo_reader;

  localparam int unsigned DW  = 64;
  localparam int unsigned FS  = 512;
  localparam int unsigned CW  = 16;
  localparam int          MAX_CYC = 2000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_words;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          fifo_rd_clr_n;
  logic          fifo_wr_clr_n;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
  logic          ovf_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Environment FIFO and expected output stream.
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];

  // Per-transaction monitor state.
  bit            mon_en = 1'b0;
  int            exp_n, rd_cnt, pop_cnt, done_cnt, first_rd_cyc, last_pop_cyc;
  bit            seen_valid, prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  ofm_fifo_reader #(
    .DATA_WIDTH(DW),
    .FIFO_SIZE (FS),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_words     (num_words),
    .fifo_wr_en_mon(fifo_wr_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_clr_n (fifo_rd_clr_n),
    .fifo_wr_clr_n (fifo_wr_clr_n),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy),
    .done          (done),
    .ovf_err       (ovf_err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  task automatic clr_mon(input int n);
    exp_q.delete();
    exp_n        = n;
    rd_cnt       = 0;
    pop_cnt      = 0;
    done_cnt     = 0;
    first_rd_cyc = -1;
    last_pop_cyc = -1;
    seen_valid   = 1'b0;
    prev_stall   = 1'b0;
  endtask

  // FIFO model: cleared by the clear strobe, read data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (!fifo_wr_clr_n) begin
      fifo_q.delete();
    end else begin
      if (fifo_rd_en && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
      if (fifo_wr_en && fifo_q.size() < FS) fifo_q.push_back(fifo_wr_data);
    end
  end

  // Stream monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;

      if (m_valid) check("buf_bound", (rd_cnt - pop_cnt) <= 2, 1);

      if (fifo_rd_en) begin
        check("rd_en_occ", fifo_q.size() > 0, 1);
        check("rd_en_busy", busy, 1);
        check("rd_en_room", (rd_cnt - pop_cnt - int'(m_valid && m_ready)) < 2, 1);
        check("rd_en_count", rd_cnt < exp_n, 1);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        rd_cnt++;
      end

      if (m_valid && !seen_valid) begin
        seen_valid = 1'b1;
        check("first_valid_latency", cyc - first_rd_cyc, 2);
      end

      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 0, 1);
        end else begin
          check("data_order", m_data, exp_q.pop_front());
        end
        check("last_flag", m_last, pop_cnt == exp_n - 1);
        pop_cnt++;
        last_pop_cyc = cyc;
      end

      if (done) begin
        done_cnt++;
        if (exp_n > 0) check("done_after_last", cyc - last_pop_cyc, 1);
      end
    end
  end

  // gap: idle cycles between writes; rmode 0 = ready high, 1 = toggle, 2 = random.
  task automatic run_txn(input int n, input int gap, input int rmode, input string tag);
    int wr_left, gap_cnt, budget;
    clr_mon(n);
    check({tag, "_idle_clr"}, {fifo_rd_clr_n, fifo_wr_clr_n}, 2'b11);
    start     = 1'b1;
    num_words = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_clear_clr"}, {fifo_rd_clr_n, fifo_wr_clr_n}, 2'b00);
    check({tag, "_ovf_cleared"}, ovf_err, 0);
    check({tag, "_busy"}, busy, 1);
    @(posedge clk); #1;
    check({tag, "_run_clr"}, {fifo_rd_clr_n, fifo_wr_clr_n}, 2'b11);
    if (n == 0) check({tag, "_zero_done"}, done, 1);
    wr_left = n;
    gap_cnt = 0;
    budget  = 0;
    while (done_cnt == 0 && budget < MAX_CYC) begin
      fifo_wr_en = 1'b0;
      if (wr_left > 0 && gap_cnt == 0) begin
        fifo_wr_en   = 1'b1;
        fifo_wr_data = rand_word();
        exp_q.push_back(fifo_wr_data);
        wr_left--;
        gap_cnt = gap;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      budget++;
    end
    fifo_wr_en = 1'b0;
    m_ready    = 1'b1;
    check({tag, "_no_timeout"}, budget < MAX_CYC, 1);
    check({tag, "_words_out"}, pop_cnt, n);
    check({tag, "_reads"}, rd_cnt, n);
    check({tag, "_exp_empty"}, exp_q.size(), 0);
    check({tag, "_idle_after"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_done_once"}, done_cnt, 1);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    num_words    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    m_ready      = 1'b1;
    #12;
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_clr", {fifo_rd_clr_n, fifo_wr_clr_n}, 2'b00);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    run_txn(8, 0, 0, "basic");
    run_txn(16, 0, 1, "backpressure");
    run_txn(4, 4, 0, "starve");
    for (int k = 0; k < 3; k++) begin
      run_txn(int'($urandom_range(1, 30)), int'($urandom_range(0, 3)), 2, "random");
    end
    run_txn(0, 0, 0, "zero");

    // Overflow while idle: the 513th write finds the FIFO full.
    clr_mon(0);
    for (int i = 0; i < FS + 1; i++) begin
      fifo_wr_en   = 1'b1;
      fifo_wr_data = rand_word();
      @(posedge clk); #1;
      if (i == FS - 1) check("ovf_not_yet", ovf_err, 0);
    end
    fifo_wr_en = 1'b0;
    check("ovf_set", ovf_err, 1);
    check("ovf_occ_sat", dut.occ_q, FS);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_sticky", ovf_err, 1);
    run_txn(3, 1, 0, "after_ovf");

    // Reset in the middle of a drain with the buffer full.
    clr_mon(16);
    start     = 1'b1;
    num_words = CW'(16);
    m_ready   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      fifo_wr_en   = 1'b1;
      fifo_wr_data = rand_word();
      exp_q.push_back(fifo_wr_data);
      @(posedge clk); #1;
    end
    fifo_wr_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrun_valid", m_valid, 1);
    check("midrun_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_last", m_last, 0);
    check("arst_rd_en", fifo_rd_en, 0);
    check("arst_done", done, 0);
    check("arst_clr", {fifo_rd_clr_n, fifo_wr_clr_n}, 2'b00);
    check("arst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    clr_mon(0);
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", busy, 0);
    check("post_rst_valid", m_valid, 0);
    check("post_rst_clr", {fifo_rd_clr_n, fifo_wr_clr_n}, 2'b11);
    run_txn(5, 0, 2, "recover");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ofm_fifo_reader.md
OFM_FIFO_READER -- requirements
Module: ofm_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, the FIFO word width.
REQ-002 SHALL have parameter FIFO_SIZE, default 512, the attached OFM FIFO depth in words.
REQ-003 SHALL have parameter CNT_W, default 16, the width of the word-count port.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to drain num_words; honoured only in IDLE.
REQ-007 num_words  input  CNT_W  words to drain, sampled on the accepted start.
REQ-008 fifo_wr_en_mon  input  1  copy of the FIFO write strobe, for occupancy tracking.
REQ-009 fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid on the cycle after fifo_rd_en.
REQ-010 fifo_rd_en  output  1  FIFO read strobe.
REQ-011 fifo_rd_clr_n / fifo_wr_clr_n  output  1 each  active-low FIFO pointer clears.
REQ-012 m_valid / m_ready / m_data[DATA_WIDTH] / m_last  out/in/out/out  output stream.
REQ-013 busy, done, ovf_err  output  1 each  state not IDLE; 1-cycle completion pulse; sticky overflow flag.

Function
REQ-014 FSM states SHALL be IDLE, CLEAR, RUN, FLUSH, DONE.
REQ-015 IDLE + start SHALL latch num_words into remaining and move to CLEAR.
REQ-016 CLEAR SHALL last one cycle, drive both clr_n low, zero occupancy, and ignore fifo_wr_en_mon; it then SHALL go to RUN, or to DONE if remaining == 0.
REQ-017 Occupancy SHALL be CNT of clog2(FIFO_SIZE)+1 bits, updated occ <= occ + fifo_wr_en_mon - fifo_rd_en; simultaneous write and read SHALL leave it unchanged.
REQ-018 fifo_wr_en_mon with occ == FIFO_SIZE and no read SHALL set ovf_err and saturate occ; ovf_err SHALL clear only on reset or an accepted start.
REQ-019 In RUN, fifo_rd_en SHALL be combinational and assert iff all hold: occ > 0; remaining > 0; buf_cnt + inflight - pop < 2, where pop = m_valid & m_ready.
REQ-020 Each fifo_rd_en SHALL decrement remaining; RUN SHALL go to FLUSH on the cycle remaining reaches 0.
REQ-021 inflight SHALL be the registered fifo_rd_en; when set, fifo_rd_data SHALL be written into the 2-entry output buffer at that edge.
REQ-022 Latency: m_valid SHALL rise 2 cycles after the first fifo_rd_en; sustained m_ready SHALL yield 1 word/cycle.
REQ-023 m_data / m_last SHALL stay stable while m_valid & !m_ready; m_last SHALL be high only with the num_words-th word.
REQ-024 FLUSH SHALL wait until buf_cnt == 0 and inflight == 0, then go to DONE.
REQ-025 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 fifo_rd_en SHALL never assert outside RUN.
REQ-028 Words SHALL leave on m_data in FIFO order.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE; occ, remaining, buf_cnt, inflight = 0; m_valid, m_last, done, ovf_err, fifo_rd_en = 0; both clr_n = 0.
REQ-030 In IDLE, both clr_n SHALL be 1.
REQ-031 Reset mid-RUN SHALL discard buffered data with no m_valid glitch.

Structure
REQ-032 Package ofm_pkg SHALL hold the state enum, default DATA_WIDTH/FIFO_SIZE, and the occupancy-width function.
REQ-033 The 2-entry output buffer SHALL be sub-module ofm_skid_buf, with valid/ready in and out.

Verification
REQ-034 Basic drain: 8 writes, then start with num_words=8, m_ready=1 -> 8 words in order, m_valid first 2 cycles after the first rd_en, m_last on word 8, done 1 cycle later.
REQ-035 Back-pressure: m_ready toggling 1/0, num_words=16 -> no loss or duplication, data stable while stalled, buffer never exceeds 2.
REQ-036 Starvation: num_words=4, writes arrive 1 per 5 cycles -> rd_en only when occ>0, 4 words out, then done.
REQ-037 Overflow: 513 writes with no drain, FIFO_SIZE=512 -> ovf_err=1, occ=512; the next start clears ovf_err.
REQ-038 Edge and reset cases: num_words=0 -> CLEAR then done, no rd_en; rst_n low mid-RUN -> all outputs at reset values asynchronously, then IDLE.
